// File: rtl/frame_writer.sv
// frame_writer
// Write-side controller for the 4-bit grayscale frame memory read by the
// VGA display path. Takes a byte stream over a valid/ready handshake. Each
// byte holds two pixels, high nibble first. It issues one 4-bit memory write
// per pixel at sequential addresses 0 .. PIXELS-1.
//
// Parameters:
//   depth   address width; the memory holds 2**depth pixels
//   PIXELS  pixels per frame; must be even and <= 2**depth
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   start     one-cycle pulse that begins a frame load (honoured in IDLE only)
//   abort     cancels the load in progress and returns to IDLE
//   in_valid  in_data is valid
//   in_data   pixel pair: [7:4] pixel n, [3:0] pixel n+1
//   in_ready  byte accepted this cycle (combinational from state)
//   wr_ena    memory write strobe (registered)
//   wr_addr   memory write address (registered)
//   wr_data   pixel value to write (registered)
//   busy      frame load in progress (registered)
//   done      one-cycle pulse coincident with the final pixel write
module frame_writer #(
    parameter int depth  = 16,
    parameter int PIXELS = 65536
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             wr_ena,
    output logic [depth-1:0] wr_addr,
    output logic [3:0]       wr_data,
    output logic             busy,
    output logic             done
);

    if ((PIXELS % 2) != 0 || PIXELS < 2 || PIXELS > (1 << depth)) begin : g_bad_params
        $error("frame_writer: PIXELS must be even, nonzero and <= 2**depth");
    end

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCEPT = 2'd1;
    localparam logic [1:0] WR_LO  = 2'd2;

    // One bit wider than the address, so that PIXELS == 2**depth is
    // distinguishable from 0 at the end of the frame.
    localparam logic [depth:0] PIX_N = (depth+1)'(PIXELS);
    localparam logic [depth:0] TWO   = (depth+1)'(2);

    logic [1:0]     state;
    logic [depth:0] cnt;
    logic [depth:0] cnt_next;
    logic [3:0]     lo_nib;

    assign in_ready = (state == ACCEPT);
    assign cnt_next = cnt + TWO;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            lo_nib  <= '0;
            wr_ena  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // Strobes default low. wr_addr and wr_data hold their last values.
            wr_ena <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= ACCEPT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ACCEPT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (in_valid) begin
                        lo_nib  <= in_data[3:0];
                        wr_ena  <= 1'b1;
                        wr_addr <= cnt[depth-1:0];
                        wr_data <= in_data[7:4];
                        state   <= WR_LO;
                    end
                end
                WR_LO: begin
                    if (abort) begin
                        // The pending low-nibble write is dropped.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        // cnt is always even, so cnt+1 only sets bit 0.
                        wr_ena  <= 1'b1;
                        wr_addr <= {cnt[depth-1:1], 1'b1};
                        wr_data <= lo_nib;
                        cnt     <= cnt_next;
                        if (cnt_next == PIX_N) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= ACCEPT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer
// Self-checking bench for frame_writer. It uses two instances that share the
// same inputs: dut8 (depth=4, PIXELS=8) and dut16 (depth=4, PIXELS=16).
// A table of single-cycle vectors covers reset, IDLE and priority cases.
// Multi-cycle frames are checked by a scoreboard of expected writes.
module tb_frame_writer;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, in_valid;
    logic [7:0] in_data;

    logic       rdy8,  we8,  busy8,  done8;
    logic [3:0] addr8, data8;
    logic       rdy16, we16, busy16, done16;
    logic [3:0] addr16, data16;

    frame_writer #(.depth(4), .PIXELS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy8),
        .wr_ena(we8), .wr_addr(addr8), .wr_data(data8),
        .busy(busy8), .done(done8)
    );

    frame_writer #(.depth(4), .PIXELS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy16),
        .wr_ena(we16), .wr_addr(addr16), .wr_data(data16),
        .busy(busy16), .done(done16)
    );

    always #5 clk = ~clk;

    // Selects which instance the checks look at.
    bit sel16 = 1'b0;
    logic       m_rdy, m_we, m_busy, m_done;
    logic [3:0] m_addr, m_data;
    assign m_rdy  = sel16 ? rdy16  : rdy8;
    assign m_we   = sel16 ? we16   : we8;
    assign m_busy = sel16 ? busy16 : busy8;
    assign m_done = sel16 ? done16 : done8;
    assign m_addr = sel16 ? addr16 : addr8;
    assign m_data = sel16 ? data16 : data8;

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected writes
    typedef struct {
        logic [3:0] addr;
        logic [3:0] data;
        logic       done;
    } exp_t;
    exp_t sb[$];
    bit   mon_on = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (m_we) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write", m_addr, m_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_addr", m_addr, e.addr);
                    check("wr_data", m_data, e.data);
                    check("done_with_write", m_done, e.done);
                end
            end else if (m_done) begin
                tests++;
                fails++;
                $display("FAIL done_without_write: done 1, expected 0");
            end
        end
    end

    // Table of single-cycle vectors. Inputs are applied, then one clock,
    // then the outputs are compared.
    typedef struct {
        logic       rst_n, start, abort, in_valid;
        logic [7:0] in_data;
        logic       e_ready, e_we, e_busy, e_done;
        logic [3:0] e_addr, e_data;
    } vec_t;
    vec_t vecs[9];

    int unsigned exp_cnt;
    int unsigned pix;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_cnt = 0;
    endtask

    // Offers one byte and waits for the handshake. When push_lo is 0, only
    // the high-nibble write is expected. waits returns the cycles spent
    // before acceptance, not counting random stall cycles.
    task automatic drive_byte(input logic [7:0] b, input bit stall, input bit push_lo,
                              output int unsigned waits);
        bit          acc;
        int unsigned n;
        exp_t        e;
        waits = 0;
        if (stall) begin
            n = $urandom_range(0, 3);
            in_valid = 1'b0;
            for (int unsigned i = 0; i < n; i++) tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        acc = 1'b0;
        for (int unsigned k = 0; k < 40 && !acc; k++) begin
            acc = m_rdy;
            if (!acc) waits++;
            tick();
            // Random deassertion while waiting, to exercise stalls.
            if (!acc && stall) in_valid = 1'($urandom_range(0, 1));
            if (!acc) in_data = in_valid ? b : 8'hEE;
            if (!in_valid && stall) begin
                tick();
                in_valid = 1'b1;
                in_data  = b;
            end
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL handshake_timeout: byte %0h not accepted, expected acceptance", b);
        end else begin
            e.addr = exp_cnt[3:0]; e.data = b[7:4]; e.done = 1'b0;
            sb.push_back(e);
            if (push_lo) begin
                e.addr = 4'(exp_cnt + 1); e.data = b[3:0];
                e.done = ((exp_cnt + 2) == pix);
                sb.push_back(e);
            end
            exp_cnt += 2;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic full_frame(input logic [7:0] bytes[], input bit stall, input bit b2b,
                              input string tag);
        int unsigned w;
        start_frame();
        foreach (bytes[i]) begin
            drive_byte(bytes[i], stall, 1'b1, w);
            if (b2b) begin
                in_valid = 1'b1;  // held high between bytes
                check({tag, "_ready_spacing"}, w, (i == 0) ? 0 : 1);
            end
        end
        in_valid = 1'b0;
        drain({tag, "_drain"});
        tick();
        check({tag, "_busy_after"}, m_busy, 1'b0);
    endtask

    initial begin
        int unsigned w;
        logic [7:0] f8[]  = '{8'h12, 8'h34, 8'h56, 8'h78};
        logic [7:0] f16[] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;

        //          rst st ab vl data    rdy we bsy dn addr data
        vecs[0] = '{1'b0,1'b1,1'b0,1'b1,8'h12, 1'b0,1'b0,1'b0,1'b0,4'h0,4'h0};
        vecs[1] = '{1'b0,1'b1,1'b0,1'b1,8'h12, 1'b0,1'b0,1'b0,1'b0,4'h0,4'h0};
        vecs[2] = '{1'b0,1'b1,1'b0,1'b1,8'h12, 1'b0,1'b0,1'b0,1'b0,4'h0,4'h0};
        vecs[3] = '{1'b1,1'b0,1'b0,1'b1,8'h55, 1'b0,1'b0,1'b0,1'b0,4'h0,4'h0}; // IDLE ignores valid
        vecs[4] = '{1'b1,1'b1,1'b1,1'b1,8'h55, 1'b0,1'b0,1'b0,1'b0,4'h0,4'h0}; // start+abort stays IDLE
        vecs[5] = '{1'b1,1'b1,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b1,1'b0,4'h0,4'h0}; // start
        vecs[6] = '{1'b1,1'b0,1'b0,1'b1,8'h9C, 1'b0,1'b1,1'b1,1'b0,4'h0,4'h9}; // accept
        vecs[7] = '{1'b1,1'b1,1'b0,1'b1,8'h11, 1'b1,1'b1,1'b1,1'b0,4'h1,4'hC}; // low write, start ignored
        vecs[8] = '{1'b1,1'b0,1'b1,1'b1,8'h22, 1'b0,1'b0,1'b0,1'b0,4'h1,4'hC}; // abort, outputs hold

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; start = vecs[i].start; abort = vecs[i].abort;
            in_valid = vecs[i].in_valid; in_data = vecs[i].in_data;
            tick();
            check($sformatf("vec%0d_in_ready", i), m_rdy,  vecs[i].e_ready);
            check($sformatf("vec%0d_wr_ena", i),   m_we,   vecs[i].e_we);
            check($sformatf("vec%0d_busy", i),     m_busy, vecs[i].e_busy);
            check($sformatf("vec%0d_done", i),     m_done, vecs[i].e_done);
            check($sformatf("vec%0d_wr_addr", i),  m_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_wr_data", i),  m_data, vecs[i].e_data);
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;

        // Scoreboard-driven sequences on the PIXELS=8 instance
        pix = 8;
        do_reset();
        mon_on = 1'b1;
        full_frame(f8, 1'b0, 1'b1, "b2b");
        full_frame(f8, 1'b1, 1'b0, "stall");

        // Abort in the cycle after acceptance: only the high nibble is written.
        start_frame();
        drive_byte(8'hAB, 1'b0, 1'b0, w);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", m_busy, 1'b0);
        check("abort_ready", m_rdy, 1'b0);
        for (int unsigned i = 0; i < 4; i++) tick();
        check("abort_no_extra", sb.size(), 0);
        full_frame(f8, 1'b0, 1'b0, "after_abort");

        // Reset in the cycle after acceptance
        start_frame();
        drive_byte(8'h5E, 1'b0, 1'b0, w);
        rst_n = 1'b0;
        tick();
        check("rst_mid_in_ready", m_rdy,  1'b0);
        check("rst_mid_wr_ena",   m_we,   1'b0);
        check("rst_mid_busy",     m_busy, 1'b0);
        check("rst_mid_done",     m_done, 1'b0);
        check("rst_mid_wr_addr",  m_addr, 4'h0);
        check("rst_mid_wr_data",  m_data, 4'h0);
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 4; i++) tick();
        check("rst_mid_no_writes", sb.size(), 0);

        // Boundary test on the PIXELS=16 instance. The final address is 15
        // and must not wrap to 0. A start while busy is ignored.
        mon_on = 1'b0;
        sel16 = 1'b1;
        pix = 16;
        do_reset();
        mon_on = 1'b1;
        start_frame();
        foreach (f16[i]) begin
            if (i == 4) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check("busy_start_ignored", m_busy, 1'b1);
            end
            drive_byte(f16[i], 1'b0, 1'b1, w);
        end
        drain("wide_drain");
        for (int unsigned i = 0; i < 3; i++) tick();
        check("wide_busy_after", m_busy, 1'b0);
        check("wide_last_addr", m_addr, 4'hF);
        mon_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
